// File: rtl/gf2m_reduce_seq.sv
// gf2m_reduce_seq: sequential GF(2^N) reduction of a (2N-1)-bit carry-less product,
// one degree per clock from the top, with valid/ready on both sides.
`default_nettype none

module gf2m_reduce_seq #(
  parameter int         N    = 8,
  parameter logic [N:0] POLY = 9'h11B
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-2:0] in_prod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_rem,
  output logic           busy
);

  localparam int PW = 2 * N - 1;
  // Counter must hold N-2; keep at least one bit so N = 2 still elaborates.
  localparam int CW = (N > 2) ? $clog2(N - 1) : 1;

  localparam logic [PW-1:0] POLY_EXT = PW'(POLY);
  localparam logic [PW-1:0] DEG_N    = PW'(1) << N;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   acc, acc_nx;
  logic [CW-1:0]   cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_nx   = in_prod;
          cnt_nx   = CW'(N - 2);
          state_nx = REDUCE;
        end
      end
      REDUCE: begin
        // Cancel degree N+cnt if present; the step count is fixed, never data dependent.
        if (|(acc & (DEG_N << cnt)))
          acc_nx = acc ^ (POLY_EXT << cnt);
        if (cnt == '0)
          state_nx = DONE;
        else
          cnt_nx = cnt - 1'b1;
      end
      DONE: begin
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == REDUCE) || (state == DONE);
  assign out_rem   = acc[N-1:0];

endmodule

`default_nettype wire

// File: tb/tb_gf2m_reduce_seq.sv
// Self-checking bench for gf2m_reduce_seq (N = 8, POLY = 0x11B) with a
// power-table reference model and a randomized streaming scoreboard.
`default_nettype none

module tb_gf2m_reduce_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_rem;
  logic        busy;

  int total = 0;
  int bad   = 0;

  gf2m_reduce_seq #(.N(8), .POLY(9'h11B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rem   (out_rem),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: XOR of x^i mod P over the set bits, with x^i built by repeated xtime.
  function automatic logic [7:0] ref_mod(input logic [14:0] p);
    logic [7:0] pw, r;
    pw = 8'h01;
    r  = 8'h00;
    for (int i = 0; i < 15; i++) begin
      if (p[i]) r = r ^ pw;
      pw = {pw[6:0], 1'b0} ^ (pw[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  // Stimulus only: pulse one product in, return cycles until out_valid (50 = timeout).
  task automatic send(input logic [14:0] p, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = p;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_rem !== 8'h00) begin bad++; $display("FAIL reset_out_rem got=%h exp=00", out_rem); end
    rst_n = 1'b1;
  endtask

  task automatic test_aes();
    int lat;
    send(15'h2B79, lat);
    total++; if (lat !== 7) begin bad++; $display("FAIL aes_latency got=%0d exp=7", lat); end
    total++; if (out_rem !== 8'hC1) begin bad++; $display("FAIL aes_rem got=%h exp=c1", out_rem); end
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL aes_busy got=%b/%b exp=1/0", busy, in_ready); end
    drain();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL aes_drain got=%b/%b exp=1/0", in_ready, out_valid); end
  endtask

  task automatic test_no_reduce();
    int lat;
    send(15'h00A5, lat);
    total++; if (lat !== 7) begin bad++; $display("FAIL noreduce_latency got=%0d exp=7", lat); end
    total++; if (out_rem !== 8'hA5) begin bad++; $display("FAIL noreduce_rem got=%h exp=a5", out_rem); end
    drain();
  endtask

  task automatic test_top_degree();
    int lat;
    send(15'h4000, lat);
    total++; if (lat !== 7 || out_rem !== 8'h9A) begin bad++; $display("FAIL top_x14 got=%h lat=%0d exp=9a lat=7", out_rem, lat); end
    drain();
    send(15'h0100, lat);
    total++; if (lat !== 7 || out_rem !== 8'h1B) begin bad++; $display("FAIL top_x8 got=%h lat=%0d exp=1b lat=7", out_rem, lat); end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    int errs;
    send(15'h2B79, lat);
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_rem !== 8'hC1 || out_valid !== 1'b1 || in_ready !== 1'b0) errs++;
      in_valid = (c == 5) || (c == 6);
      in_prod  = 15'h1234;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles exp=0", errs); end
    total++; if (out_rem !== 8'hC1) begin bad++; $display("FAIL bp_rem got=%h exp=c1", out_rem); end
    drain();
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b exp=1/0", in_ready, busy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = 15'h2B79;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL midreset got=%b/%b/%b exp=0/1/0", out_valid, in_ready, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    send(15'h0100, lat);
    total++; if (lat !== 7 || out_rem !== 8'h1B) begin bad++; $display("FAIL midreset_next got=%h lat=%0d exp=1b lat=7", out_rem, lat); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
      in_prod   = 15'($urandom);
      out_ready = $urandom_range(1) != 0;
      #1;
      // Handshakes decided here fire on the coming rising edge.
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mod(in_prod));
        sent++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra got=%h exp=no output", out_rem);
        end else begin
          e = exp_q.pop_front();
          if (out_rem !== e) begin bad++; $display("FAIL b2b_rem idx=%0d got=%h exp=%h", got, out_rem, e); end
        end
        got++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++; if (got !== 1000 || sent !== 1000 || exp_q.size() !== 0) begin bad++; $display("FAIL b2b_count got=%0d sent=%0d pend=%0d exp=1000/1000/0", got, sent, exp_q.size()); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_aes();
    test_no_reduce();
    test_top_degree();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
